// File: rtl/qtz_level_hv_bank.sv
// qtz_level_hv_bank
// Level-hypervector store that sits between the level-HV loader and the
// spatial encoder. It holds NUM_LEVELS hypervectors. Each one is loaded as
// NSEG segments over a valid/ready stream into a staging register. The
// staged HV is then committed to its entry in a single cycle, so a reader
// never sees a half-written HV.
//
// Optional feature macro: QTZ_LVL_PARITY_EN
//   When defined, each entry stores one even-parity bit per segment. The
//   parity is checked on every read hit, and the ports inj_par and
//   rd_par_err are added.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   wr_valid/wr_ready   write segment handshake
//   wr_idx              target level, sampled on the first beat only
//   wr_seg              segment data; beat k fills bits [k*SEG_W +: SEG_W]
//   wr_abort            drop the in-progress load
//   clear               invalidate all levels and clear err_idx
//   rd_en/rd_idx        read request (1-cycle latency)
//   rd_valid/rd_hit     read response valid / addressed level was valid
//   rd_data             level HV, or 0 on a miss
//   level_valid         per-level committed bitmap
//   busy                load FSM not idle
//   err_idx             sticky out-of-range write index flag
//   inj_par             (parity build) XOR mask into stored parity at commit
//   rd_par_err          (parity build) parity mismatch on a read hit
module qtz_level_hv_bank #(
  parameter int HV_DIM     = 1024,
  parameter int SEG_W      = 64,
  parameter int NUM_LEVELS = 9,
  localparam int IDX_W     = $clog2(NUM_LEVELS),
  localparam int NSEG      = HV_DIM / SEG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [SEG_W-1:0]      wr_seg,
  input  logic                  wr_abort,
  input  logic                  clear,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic                  rd_hit,
  output logic [HV_DIM-1:0]     rd_data,
`ifdef QTZ_LVL_PARITY_EN
  input  logic [NSEG-1:0]       inj_par,
  output logic                  rd_par_err,
`endif
  output logic [NUM_LEVELS-1:0] level_valid,
  output logic                  busy,
  output logic                  err_idx
);

  // Reject parameter sets the segment and index arithmetic cannot support.
  generate
    if (HV_DIM % SEG_W != 0) begin : g_bad_seg
      $error("qtz_level_hv_bank: HV_DIM must be a multiple of SEG_W");
    end
    if (NUM_LEVELS < 2 || NUM_LEVELS > 64) begin : g_bad_levels
      $error("qtz_level_hv_bank: NUM_LEVELS must be in 2..64");
    end
  endgenerate

  // seg_cnt must be able to hold the value NSEG-1. One extra bit is kept so
  // that NSEG==1 still gets a valid counter width.
  localparam int CNT_W = $clog2(NSEG + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMMIT} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       seg_cnt;
  logic [IDX_W-1:0]       cur_idx;
  logic [HV_DIM-1:0]      staging;
  logic [HV_DIM-1:0]      entries [NUM_LEVELS];
  logic                   beat;
  logic                   cur_in_range;
  logic                   rd_in_range;
  logic                   rd_hit_now;

`ifdef QTZ_LVL_PARITY_EN
  logic [NSEG-1:0]        par_mem [NUM_LEVELS];

  // Even-parity bit per segment: the XOR of that segment's bits.
  function automatic logic [NSEG-1:0] seg_parity(input logic [HV_DIM-1:0] hv);
    logic [NSEG-1:0] p;
    p = '0;
    for (int s = 0; s < NSEG; s++) begin
      p[s] = ^hv[s*SEG_W +: SEG_W];
    end
    return p;
  endfunction
`endif

  // The index compares are done one bit wider than IDX_W, so that
  // NUM_LEVELS==64 does not truncate to zero.
  assign cur_in_range = {1'b0, cur_idx} < (IDX_W+1)'(NUM_LEVELS);
  assign rd_in_range  = {1'b0, rd_idx}  < (IDX_W+1)'(NUM_LEVELS);
  assign rd_hit_now   = rd_in_range && level_valid[rd_idx];

  assign wr_ready = (state != ST_COMMIT);
  assign busy     = (state != ST_IDLE);
  assign beat     = wr_valid && wr_ready;

  // Load FSM, entry storage and the registered read port.
  // clear is applied after the case statement, so it overrides anything the
  // commit did to the valid bits or to err_idx. Reads sample the array
  // before this edge's commit lands, which gives read-before-write on a
  // collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      seg_cnt     <= '0;
      cur_idx     <= '0;
      staging     <= '0;
      level_valid <= '0;
      err_idx     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_hit      <= 1'b0;
      rd_data     <= '0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
        entries[i] <= '0;
      end
`ifdef QTZ_LVL_PARITY_EN
      rd_par_err  <= 1'b0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
        par_mem[i] <= '0;
      end
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!clear && beat) begin
            cur_idx               <= wr_idx;
            staging[0 +: SEG_W]   <= wr_seg;
            seg_cnt               <= CNT_W'(1);
            state                 <= (NSEG == 1) ? ST_COMMIT : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (clear || wr_abort) begin
            state   <= ST_IDLE;
            seg_cnt <= '0;
          end else if (beat) begin
            staging[int'(seg_cnt)*SEG_W +: SEG_W] <= wr_seg;
            seg_cnt <= seg_cnt + CNT_W'(1);
            if (seg_cnt == CNT_W'(NSEG - 1)) begin
              state <= ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          if (cur_in_range) begin
            entries[cur_idx]     <= staging;
            level_valid[cur_idx] <= 1'b1;
`ifdef QTZ_LVL_PARITY_EN
            par_mem[cur_idx]     <= seg_parity(staging) ^ inj_par;
`endif
          end else begin
            err_idx <= 1'b1;
          end
          seg_cnt <= '0;
          state   <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          seg_cnt <= '0;
        end
      endcase

      if (clear) begin
        level_valid <= '0;
        err_idx     <= 1'b0;
      end

      rd_valid <= rd_en;
      if (rd_en) begin
        rd_hit  <= rd_hit_now;
        rd_data <= rd_hit_now ? entries[rd_idx] : '0;
`ifdef QTZ_LVL_PARITY_EN
        rd_par_err <= rd_hit_now &&
                      (|(seg_parity(entries[rd_idx]) ^ par_mem[rd_idx]));
`endif
      end
    end
  end

endmodule

// File: tb/tb_qtz_level_hv_bank.sv
// tb_qtz_level_hv_bank
// Directed bench for qtz_level_hv_bank with HV_DIM=256, SEG_W=64 and
// NUM_LEVELS=9. The stimulus process pushes the expected read response into
// a scoreboard queue each time it issues a read. A separate monitor pops and
// compares whenever rd_valid is high. Handshake, bitmap and flag checks are
// made inline by the stimulus process.
module tb_qtz_level_hv_bank;

  localparam int HV_DIM     = 256;
  localparam int SEG_W      = 64;
  localparam int NUM_LEVELS = 9;
  localparam int IDX_W      = 4;
  localparam int NSEG       = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [IDX_W-1:0]      wr_idx;
  logic [SEG_W-1:0]      wr_seg;
  logic                  wr_abort;
  logic                  clear;
  logic                  rd_en;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_valid;
  logic                  rd_hit;
  logic [HV_DIM-1:0]     rd_data;
  logic [NUM_LEVELS-1:0] level_valid;
  logic                  busy;
  logic                  err_idx;
`ifdef QTZ_LVL_PARITY_EN
  logic [NSEG-1:0]       inj_par;
  logic                  rd_par_err;
`endif

  typedef struct packed {
    logic              hit;
    logic              par_err;
    logic [HV_DIM-1:0] data;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  rd_exp_t mon_exp;
  int      total_cnt = 0;
  int      pass_cnt  = 0;

  localparam logic [HV_DIM-1:0] HV1 = {64'h4444444444444444, 64'h3333333333333333,
                                       64'h2222222222222222, 64'h1111111111111111};
  localparam logic [HV_DIM-1:0] HV7 = {64'hDEADBEEF00000007, 64'h0123456789ABCDEF,
                                       64'hFEDCBA9876543210, 64'h7777777777777777};
  localparam logic [HV_DIM-1:0] HVX = {64'hC0FFEE0000000010, 64'h0000000000000010,
                                       64'h1010101010101010, 64'hFFFFFFFFFFFFFFFF};
  localparam logic [HV_DIM-1:0] HVA = {64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2,
                                       64'hA1A1A1A1A1A1A1A1, 64'hA0A0A0A0A0A0A0A0};
  localparam logic [HV_DIM-1:0] HVB = {64'hB3B3B3B3B3B3B3B3, 64'hB2B2B2B2B2B2B2B2,
                                       64'hB1B1B1B1B1B1B1B1, 64'hB0B0B0B0B0B0B0B0};

  qtz_level_hv_bank #(
    .HV_DIM     (HV_DIM),
    .SEG_W      (SEG_W),
    .NUM_LEVELS (NUM_LEVELS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_idx      (wr_idx),
    .wr_seg      (wr_seg),
    .wr_abort    (wr_abort),
    .clear       (clear),
    .rd_en       (rd_en),
    .rd_idx      (rd_idx),
    .rd_valid    (rd_valid),
    .rd_hit      (rd_hit),
    .rd_data     (rd_data),
`ifdef QTZ_LVL_PARITY_EN
    .inj_par     (inj_par),
    .rd_par_err  (rd_par_err),
`endif
    .level_valid (level_valid),
    .busy        (busy),
    .err_idx     (err_idx)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [HV_DIM-1:0] act,
                              input logic [HV_DIM-1:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives four beats. wr_idx is scrambled after the first beat because the
  // DUT must ignore it during the load. Returns while the DUT is in COMMIT.
  task automatic apply_stimulus(input logic [IDX_W-1:0] idx, input logic [HV_DIM-1:0] hv);
    for (int k = 0; k < NSEG; k++) begin
      wr_valid = 1'b1;
      wr_idx   = (k == 0) ? idx : 4'hF;
      wr_seg   = hv[k*SEG_W +: SEG_W];
      tick();
    end
    wr_valid = 1'b0;
    check_output("commit_ready_low", HV_DIM'(wr_ready), HV_DIM'(1'b0));
    check_output("commit_busy", HV_DIM'(busy), HV_DIM'(1'b1));
  endtask

  task automatic issue_read(input logic [IDX_W-1:0] idx, input logic hit,
                            input logic [HV_DIM-1:0] data, input logic par_err);
    rd_exp_t e;
    e.hit     = hit;
    e.par_err = par_err;
    e.data    = data;
    sb_q.push_back(e);
    rd_en  = 1'b1;
    rd_idx = idx;
    tick();
    rd_en  = 1'b0;
  endtask

  // Scoreboard monitor: compares each read response against the queue.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("[TB] FAIL sb_unexpected actual=rd_valid required=no_response");
      end else begin
        mon_exp = sb_q.pop_front();
        check_output("rd_hit", HV_DIM'(rd_hit), HV_DIM'(mon_exp.hit));
        check_output("rd_data", rd_data, mon_exp.data);
`ifdef QTZ_LVL_PARITY_EN
        check_output("rd_par_err", HV_DIM'(rd_par_err), HV_DIM'(mon_exp.par_err));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_idx = '0; wr_seg = '0; wr_abort = 1'b0;
    clear = 1'b0; rd_en = 1'b0; rd_idx = '0;
`ifdef QTZ_LVL_PARITY_EN
    inj_par = '0;
`endif
    tick();
    tick();
    check_output("rst_wr_ready", HV_DIM'(wr_ready), HV_DIM'(1'b1));
    check_output("rst_rd_valid", HV_DIM'(rd_valid), HV_DIM'(1'b0));
    check_output("rst_rd_hit", HV_DIM'(rd_hit), HV_DIM'(1'b0));
    check_output("rst_rd_data", rd_data, '0);
    check_output("rst_level_valid", HV_DIM'(level_valid), '0);
    check_output("rst_busy", HV_DIM'(busy), HV_DIM'(1'b0));
    check_output("rst_err_idx", HV_DIM'(err_idx), HV_DIM'(1'b0));
    rst = 1'b0;

    // Back-to-back load of level 3, then read it.
    apply_stimulus(4'd3, HV1);
    tick();
    check_output("post_commit_ready", HV_DIM'(wr_ready), HV_DIM'(1'b1));
    check_output("lv_after_3", HV_DIM'(level_valid), HV_DIM'(9'h008));
    issue_read(4'd3, 1'b1, HV1, 1'b0);
    tick();
    check_output("rd_valid_idle", HV_DIM'(rd_valid), HV_DIM'(1'b0));
    check_output("rd_data_hold", rd_data, HV1);

    // Misses: a level that was never loaded, and an out-of-range index.
    issue_read(4'd5, 1'b0, '0, 1'b0);
    issue_read(4'd12, 1'b0, '0, 1'b0);

    // Abort a partial load of level 7. The beat in the abort cycle is dropped.
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      wr_idx   = 4'd7;
      wr_seg   = 64'hBAD0BAD0BAD00000 | 64'(k);
      wr_abort = (k == 2);
      tick();
    end
    wr_valid = 1'b0;
    wr_abort = 1'b0;
    check_output("abort_busy", HV_DIM'(busy), HV_DIM'(1'b0));
    check_output("abort_lv", HV_DIM'(level_valid), HV_DIM'(9'h008));
    apply_stimulus(4'd7, HV7);
    tick();
    check_output("lv_after_7", HV_DIM'(level_valid), HV_DIM'(9'h088));
    issue_read(4'd7, 1'b1, HV7, 1'b0);

    // An out-of-range write sets err_idx. A following clear drops it and
    // every valid bit.
    apply_stimulus(4'd10, HVX);
    tick();
    check_output("err_idx_set", HV_DIM'(err_idx), HV_DIM'(1'b1));
    check_output("err_lv_same", HV_DIM'(level_valid), HV_DIM'(9'h088));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_output("clear_err_idx", HV_DIM'(err_idx), HV_DIM'(1'b0));
    check_output("clear_lv", HV_DIM'(level_valid), '0);
    issue_read(4'd3, 1'b0, '0, 1'b0);

    // Read in the same cycle as the commit: old data, then new data.
    apply_stimulus(4'd2, HVA);
    tick();
    issue_read(4'd2, 1'b1, HVA, 1'b0);
    apply_stimulus(4'd2, HVB);
    issue_read(4'd2, 1'b1, HVA, 1'b0);
    issue_read(4'd2, 1'b1, HVB, 1'b0);
    check_output("lv_after_2", HV_DIM'(level_valid), HV_DIM'(9'h004));

`ifdef QTZ_LVL_PARITY_EN
    // A flipped parity bit for segment 2 must be reported on read.
    inj_par = 4'b0100;
    apply_stimulus(4'd1, HV1);
    tick();
    inj_par = '0;
    issue_read(4'd1, 1'b1, HV1, 1'b1);
    apply_stimulus(4'd1, HV1);
    tick();
    issue_read(4'd1, 1'b1, HV1, 1'b0);
`endif

    tick();
    tick();
    check_output("sb_drain", HV_DIM'(sb_q.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
